punc_mem_arbiter: RTL and testbench
===================================

# punc_mem_arbiter

Single-port memory arbiter for the PUnC LC3 processor. It shares one synchronous memory between two requesters: the CPU port, driven by the PUnC control/datapath for fetch, LD/LDI/LDR, ST/STI/STR, and the debug port, used by the program loader and memory inspector. It issues at most one access per cycle, tracks outstanding read latency, and breaks contention round-robin so neither port starves.

## Interface
- AW, 16, address width
- DW, 16, data width
- RD_LAT, 1, memory read latency in cycles (legal 1..4)

- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  request accepted this cycle (combinational)
- cpu_rvalid  out  1  read data valid, one-cycle pulse
- cpu_rdata  out  DW  read data, meaningful only when cpu_rvalid
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same directions, widths and meanings as the cpu_* set, for the debug port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after mem_en with mem_we=0
- busy  out  1  read outstanding

## Operation
- States: IDLE and RD_WAIT. A counter rd_cnt (0..RD_LAT) and an owner flag rd_owner record the outstanding read.
- Grant eligibility: the arbiter may grant when in IDLE, or when in RD_WAIT and rd_cnt==1 (the final cycle of the read, when rvalid fires).
- When eligible and exactly one req is high, grant that port.
- When eligible and both reqs are high, grant the port that is not last_gnt. last_gnt updates on every grant and resets to DBG, so the CPU wins the first tie.
- When not eligible, both gnt outputs are 0. Requesters hold req, we, addr and wdata stable until gnt.
- Granted cycle: mem_en=1. mem_we, mem_addr and mem_wdata are taken from the granted port. Exactly one gnt is high whenever mem_en is high.
- Write grant: the arbiter stays in or returns to IDLE. Back-to-back writes are allowed every cycle.
- Read grant: rd_cnt<=RD_LAT, rd_owner<=port, and the state goes to RD_WAIT. rd_cnt decrements each cycle. On the rd_cnt==1 cycle, the owner's rvalid=1 and its rdata=mem_rdata (passthrough); the cycle then reaches rd_cnt 0 and the state goes to IDLE unless a new read is granted in that same cycle.
- The non-owner's rvalid stays 0. rdata outputs are mem_rdata when valid and 0 otherwise.
- busy=1 in RD_WAIT.
- When no port is granted, mem_we, mem_addr and mem_wdata are 0.

## Timing
- Reset: state=IDLE, rd_cnt=0, last_gnt=DBG. All outputs are 0: gnt, rvalid, rdata, mem_*, busy.
- Reset asserted mid-read aborts the read. No rvalid is produced, including when reset lands on the would-be rvalid cycle.
- Read latency: rvalid arrives RD_LAT cycles after the gnt cycle.
- Read throughput: one read per RD_LAT cycles. With RD_LAT=1, reads can be granted every cycle, and rvalid for read N coincides with the grant of read N+1.
- Write latency: the memory captures the write at the clock edge that ends the gnt cycle. No response is returned.
- A write requested while a read is outstanding waits until the rd_cnt==1 cycle.
- Requests arriving in the same cycle are arbitrated immediately. No bubble is inserted between different owners.

## Test plan
- RD_LAT=1, CPU reads 0x3000, memory returns 0x1234: cpu_gnt and mem_en=1 in cycle 0, mem_addr=0x3000, cpu_rvalid=1 with cpu_rdata=0x1234 in cycle 1, dbg_rvalid stays 0.
- Both ports request reads continuously from reset with RD_LAT=1: grants go CPU, DBG, CPU, DBG…, one per cycle, and each rvalid is routed to the correct owner with the correct data.
- RD_LAT=3, CPU read at cycle 0 and DBG write requested at cycle 1: dbg_gnt stays 0 in cycles 1–2, cpu_rvalid=1 and dbg_gnt=1 in cycle 3, busy=1 in cycles 1–3.
- CPU writes 0xBEEF to 0x0005, 0x0006 and 0x0007 on consecutive cycles: three consecutive gnt and mem_we pulses. A later CPU read of 0x0006 returns 0xBEEF.
- RD_LAT=2, DBG read granted, rst asserted in the next cycle: no dbg_rvalid, all outputs 0 after reset, and the next tie is granted to the CPU.

Source files
------------

// File: rtl/punc_mem_arbiter.sv
// Single-port memory arbiter for PUnC: shares one synchronous memory between the CPU
// and debug ports with round-robin tie-break and read-latency tracking.
module punc_mem_arbiter #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned CW = $clog2(RD_LAT + 1);

  typedef enum logic {StIdle, StRdWait} state_e;

  state_e        state_q;
  logic [CW-1:0] rd_cnt_q;
  logic          rd_owner_q;  // 1: debug port owns the outstanding read
  logic          last_gnt_q;  // 1: debug port won the most recent grant

  logic eligible;
  logic rd_done;

  // Outputs are forced low while reset is held so an aborted read never responds.
  always_comb begin
    rd_done  = !rst && (state_q == StRdWait) && (rd_cnt_q == CW'(1));
    eligible = !rst && ((state_q == StIdle) || rd_done);

    cpu_gnt = eligible && cpu_req && (!dbg_req || last_gnt_q);
    dbg_gnt = eligible && dbg_req && (!cpu_req || !last_gnt_q);

    mem_en    = cpu_gnt || dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end

    cpu_rvalid = rd_done && !rd_owner_q;
    dbg_rvalid = rd_done && rd_owner_q;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
    busy       = !rst && (state_q == StRdWait);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rd_cnt_q   <= '0;
      rd_owner_q <= 1'b0;
      last_gnt_q <= 1'b1;
    end else begin
      if (mem_en) begin
        last_gnt_q <= dbg_gnt;
      end
      if (mem_en && !mem_we) begin
        state_q    <= StRdWait;
        rd_cnt_q   <= CW'(RD_LAT);
        rd_owner_q <= dbg_gnt;
      end else if (state_q == StRdWait) begin
        rd_cnt_q <= rd_cnt_q - CW'(1);
        if (rd_cnt_q == CW'(1)) begin
          state_q <= StIdle;
        end
      end
    end
  end

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Directed bench for punc_mem_arbiter: three instances (RD_LAT = 1, 2, 3), each with
// its own latency-matched memory model.
module tb_punc_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [2:0]       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [2:0]       dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [2:0]       mem_en, mem_we, busy;
  logic [2:0][15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0][15:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [2:0][15:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = g + 1;
    logic [15:0] mem  [256];
    logic [15:0] pipe [LAT];

    punc_mem_arbiter #(.AW(16), .DW(16), .RD_LAT(LAT)) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .cpu_req    (cpu_req[g]),
      .cpu_we     (cpu_we[g]),
      .cpu_addr   (cpu_addr[g]),
      .cpu_wdata  (cpu_wdata[g]),
      .cpu_gnt    (cpu_gnt[g]),
      .cpu_rvalid (cpu_rvalid[g]),
      .cpu_rdata  (cpu_rdata[g]),
      .dbg_req    (dbg_req[g]),
      .dbg_we     (dbg_we[g]),
      .dbg_addr   (dbg_addr[g]),
      .dbg_wdata  (dbg_wdata[g]),
      .dbg_gnt    (dbg_gnt[g]),
      .dbg_rvalid (dbg_rvalid[g]),
      .dbg_rdata  (dbg_rdata[g]),
      .mem_en     (mem_en[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g]),
      .busy       (busy[g])
    );

    // Synchronous memory: 256 words, read data appears LAT cycles after the access.
    always_ff @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
      pipe[0] <= mem[mem_addr[g][7:0]];
      for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[LAT-1];
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Both-port read stream on RD_LAT=1: per-cycle expectations.
  logic [15:0] cpu_seq [4];
  logic [15:0] dbg_seq [4];
  logic [15:0] str_addr [6];
  logic [15:0] str_rd [7];
  logic [15:0] pre_addr [5];
  logic [15:0] pre_data [5];

  initial begin
    cpu_seq  = '{16'h0010, 16'h0011, 16'h0010, 16'h0011};
    dbg_seq  = '{16'h0012, 16'h0013, 16'h0012, 16'h0013};
    str_addr = '{16'h0010, 16'h0012, 16'h0011, 16'h0013, 16'h0010, 16'h0012};
    str_rd   = '{16'h0000, 16'hA001, 16'hB001, 16'hA002, 16'hB002, 16'hA001, 16'hB001};
    pre_addr = '{16'h3000, 16'h0010, 16'h0011, 16'h0012, 16'h0013};
    pre_data = '{16'h1234, 16'hA001, 16'hA002, 16'hB001, 16'hB002};

    rst = 3'b111;
    cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = '0; dbg_we = '0; dbg_addr = '0; dbg_wdata = '0;

    // Reset: requests are ignored and every output stays low.
    cpu_req[0] = 1'b1; cpu_addr[0] = 16'h0044;
    tick();
    settle();
    check_eq("rst_cpu_gnt", 16'(cpu_gnt[0]), 16'h0);
    check_eq("rst_mem_en", 16'(mem_en[0]), 16'h0);
    check_eq("rst_mem_addr", mem_addr[0], 16'h0000);
    check_eq("rst_busy", 16'(busy[0]), 16'h0);
    tick();
    rst = 3'b000;
    cpu_req[0] = 1'b0; cpu_addr[0] = '0;

    // Loader preload through the debug port, one write per cycle.
    for (int i = 0; i < 5; i++) begin
      dbg_req[0] = 1'b1; dbg_we[0] = 1'b1; dbg_addr[0] = pre_addr[i]; dbg_wdata[0] = pre_data[i];
      settle();
      check_eq("pre_dbg_gnt", 16'(dbg_gnt[0]), 16'h1);
      check_eq("pre_mem_we", 16'(mem_we[0]), 16'h1);
      tick();
    end
    dbg_req[0] = 1'b0; dbg_we[0] = 1'b0; dbg_addr[0] = '0; dbg_wdata[0] = '0;

    // RD_LAT=1 single CPU read of 0x3000.
    cpu_req[0] = 1'b1; cpu_addr[0] = 16'h3000;
    settle();
    check_eq("rd1_cpu_gnt", 16'(cpu_gnt[0]), 16'h1);
    check_eq("rd1_mem_en", 16'(mem_en[0]), 16'h1);
    check_eq("rd1_mem_addr", mem_addr[0], 16'h3000);
    check_eq("rd1_mem_we", 16'(mem_we[0]), 16'h0);
    tick();
    cpu_req[0] = 1'b0; cpu_addr[0] = '0;
    settle();
    check_eq("rd1_cpu_rvalid", 16'(cpu_rvalid[0]), 16'h1);
    check_eq("rd1_cpu_rdata", cpu_rdata[0], 16'h1234);
    check_eq("rd1_dbg_rvalid", 16'(dbg_rvalid[0]), 16'h0);
    check_eq("rd1_busy", 16'(busy[0]), 16'h1);
    tick();
    settle();
    check_eq("idle_mem_addr", mem_addr[0], 16'h0000);
    check_eq("idle_busy", 16'(busy[0]), 16'h0);

    // Fresh reset so the first tie goes to the CPU, then both ports stream reads.
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cpu_req[0] = (k < 6); dbg_req[0] = (k < 6);
      cpu_addr[0] = cpu_seq[(k + 1) / 2 % 4];
      dbg_addr[0] = dbg_seq[k / 2 % 4];
      settle();
      if (k < 6) begin
        check_eq("str_cpu_gnt", 16'(cpu_gnt[0]), 16'((k % 2) == 0));
        check_eq("str_dbg_gnt", 16'(dbg_gnt[0]), 16'((k % 2) == 1));
        check_eq("str_mem_addr", mem_addr[0], str_addr[k]);
      end
      check_eq("str_cpu_rvalid", 16'(cpu_rvalid[0]), 16'((k > 0) && ((k % 2) == 1)));
      check_eq("str_dbg_rvalid", 16'(dbg_rvalid[0]), 16'((k > 0) && ((k % 2) == 0)));
      check_eq("str_rdata", cpu_rdata[0] | dbg_rdata[0], str_rd[k]);
      tick();
    end
    cpu_req[0] = 1'b0; dbg_req[0] = 1'b0; cpu_addr[0] = '0; dbg_addr[0] = '0;

    // Back-to-back CPU writes, then read one back.
    for (int i = 0; i < 3; i++) begin
      cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 16'(5 + i); cpu_wdata[0] = 16'hBEEF;
      settle();
      check_eq("wr_cpu_gnt", 16'(cpu_gnt[0]), 16'h1);
      check_eq("wr_mem_we", 16'(mem_we[0]), 16'h1);
      check_eq("wr_mem_addr", mem_addr[0], 16'(5 + i));
      check_eq("wr_mem_wdata", mem_wdata[0], 16'hBEEF);
      tick();
    end
    cpu_we[0] = 1'b0; cpu_wdata[0] = '0; cpu_addr[0] = 16'h0006;
    settle();
    check_eq("wrb_cpu_gnt", 16'(cpu_gnt[0]), 16'h1);
    tick();
    cpu_req[0] = 1'b0; cpu_addr[0] = '0;
    settle();
    check_eq("wrb_cpu_rvalid", 16'(cpu_rvalid[0]), 16'h1);
    check_eq("wrb_cpu_rdata", cpu_rdata[0], 16'hBEEF);
    tick();

    // RD_LAT=3: a debug write waits for the final read cycle.
    dbg_req[2] = 1'b1; dbg_we[2] = 1'b1; dbg_addr[2] = 16'h0020; dbg_wdata[2] = 16'h5A5A;
    settle();
    check_eq("l3_pre_gnt", 16'(dbg_gnt[2]), 16'h1);
    tick();
    dbg_req[2] = 1'b0; dbg_we[2] = 1'b0;
    cpu_req[2] = 1'b1; cpu_addr[2] = 16'h0020;
    settle();
    check_eq("l3_c0_cpu_gnt", 16'(cpu_gnt[2]), 16'h1);
    check_eq("l3_c0_busy", 16'(busy[2]), 16'h0);
    tick();
    cpu_req[2] = 1'b0; cpu_addr[2] = '0;
    dbg_req[2] = 1'b1; dbg_we[2] = 1'b1; dbg_addr[2] = 16'h0021; dbg_wdata[2] = 16'h7777;
    for (int c = 1; c < 3; c++) begin
      settle();
      check_eq("l3_wait_dbg_gnt", 16'(dbg_gnt[2]), 16'h0);
      check_eq("l3_wait_mem_en", 16'(mem_en[2]), 16'h0);
      check_eq("l3_wait_mem_we", 16'(mem_we[2]), 16'h0);
      check_eq("l3_wait_busy", 16'(busy[2]), 16'h1);
      check_eq("l3_wait_rvalid", 16'(cpu_rvalid[2]), 16'h0);
      tick();
    end
    settle();
    check_eq("l3_c3_cpu_rvalid", 16'(cpu_rvalid[2]), 16'h1);
    check_eq("l3_c3_cpu_rdata", cpu_rdata[2], 16'h5A5A);
    check_eq("l3_c3_dbg_gnt", 16'(dbg_gnt[2]), 16'h1);
    check_eq("l3_c3_mem_addr", mem_addr[2], 16'h0021);
    check_eq("l3_c3_busy", 16'(busy[2]), 16'h1);
    tick();
    dbg_req[2] = 1'b0; dbg_we[2] = 1'b0; dbg_addr[2] = '0; dbg_wdata[2] = '0;
    settle();
    check_eq("l3_c4_busy", 16'(busy[2]), 16'h0);
    tick();

    // RD_LAT=2: reset aborts a debug read the cycle after its grant.
    dbg_req[1] = 1'b1; dbg_addr[1] = 16'h0030;
    settle();
    check_eq("l2_dbg_gnt", 16'(dbg_gnt[1]), 16'h1);
    tick();
    dbg_req[1] = 1'b0; dbg_addr[1] = '0; rst[1] = 1'b1;
    settle();
    check_eq("l2_rst_busy", 16'(busy[1]), 16'h0);
    check_eq("l2_rst_dbg_rvalid", 16'(dbg_rvalid[1]), 16'h0);
    tick();
    rst[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check_eq("l2_after_rvalid", 16'(dbg_rvalid[1]), 16'h0);
      check_eq("l2_after_busy", 16'(busy[1]), 16'h0);
      tick();
    end

    // CPU read, reset landing on its would-be rvalid cycle, then a tie goes to the CPU.
    cpu_req[1] = 1'b1; cpu_addr[1] = 16'h0031;
    settle();
    check_eq("l2b_cpu_gnt", 16'(cpu_gnt[1]), 16'h1);
    tick();
    cpu_req[1] = 1'b0; cpu_addr[1] = '0;
    tick();
    rst[1] = 1'b1;
    settle();
    check_eq("l2b_rst_cpu_rvalid", 16'(cpu_rvalid[1]), 16'h0);
    check_eq("l2b_rst_cpu_rdata", cpu_rdata[1], 16'h0000);
    check_eq("l2b_rst_busy", 16'(busy[1]), 16'h0);
    tick();
    rst[1] = 1'b0;
    cpu_req[1] = 1'b1; dbg_req[1] = 1'b1; cpu_addr[1] = 16'h0032; dbg_addr[1] = 16'h0033;
    settle();
    check_eq("l2b_tie_cpu_gnt", 16'(cpu_gnt[1]), 16'h1);
    check_eq("l2b_tie_dbg_gnt", 16'(dbg_gnt[1]), 16'h0);
    check_eq("l2b_tie_mem_addr", mem_addr[1], 16'h0032);
    tick();
    cpu_req[1] = 1'b0; dbg_req[1] = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
